inv_sub_bytes_seq: RTL and testbench

INV_SUB_BYTES_SEQ -- requirements
Module: inv_sub_bytes_seq

---
 rtl/inv_sub_bytes_seq_pkg.sv | 22 ++
 rtl/InverseSbox.sv | 33 +++
 rtl/inv_sub_bytes_seq.sv | 104 ++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/inv_sub_bytes_seq_pkg.sv
// Shared definitions for the sequential inverse-SubBytes block.
//   state_e      : FSM state encoding (IDLE, RUN, DONE)
//   STATE_BYTES  : number of bytes in one AES state
//   CHUNKS       : chunk count at the default bytes-per-cycle
//   chunks_for() : chunk count for an arbitrary bytes-per-cycle setting
package inv_sub_bytes_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int STATE_BYTES             = 16;
    localparam int DEFAULT_BYTES_PER_CYCLE = 4;
    localparam int CHUNKS                  = STATE_BYTES / DEFAULT_BYTES_PER_CYCLE;

    function automatic int chunks_for(input int bytes_per_cycle);
        return STATE_BYTES / bytes_per_cycle;
    endfunction

endpackage

// File: rtl/InverseSbox.sv
// AES inverse S-box, purely combinational.
//   a : input byte
//   c : inverse-substituted byte
// The table is packed with entry 0 in the most significant byte.
module InverseSbox (
    input  logic [7:0] a,
    output logic [7:0] c
);

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    always_comb begin
        c = INV_SBOX[(255 - int'(a)) * 8 +: 8];
    end

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES inverse SubBytes: substitutes BYTES_PER_CYCLE bytes of the
// captured state per clock, then presents the whole result.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; ready never depends on valid, and a producer holds its data
// stable while valid is high and ready is low.
//   clk, rst        : clock, asynchronous active-high reset
//   in_valid/ready  : input handshake, in_state = 128-bit state (byte k at [8k+7:8k])
//   out_valid/ready : output handshake, out_state = substituted state
//   busy            : FSM not in IDLE
//   state_dbg       : current FSM state
module inv_sub_bytes_seq
    import inv_sub_bytes_seq_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = DEFAULT_BYTES_PER_CYCLE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy,
    output state_e       state_dbg
);

    localparam int NUM_CHUNKS = chunks_for(BYTES_PER_CYCLE);
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int CHUNK_W    = 8 * BYTES_PER_CYCLE;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [127:0]       work_q, work_d;
    logic [CHUNK_W-1:0] chunk_in, chunk_out;

    // Chunk select: one-hot compare against cnt keeps every slice in range.
    always_comb begin
        chunk_in = '0;
        for (int c = 0; c < NUM_CHUNKS; c++) begin
            if (cnt_q == CNT_W'(c)) chunk_in = work_q[c*CHUNK_W +: CHUNK_W];
        end
    end

    for (genvar b = 0; b < BYTES_PER_CYCLE; b++) begin : g_sbox
        InverseSbox u_inv_sbox (
            .a (chunk_in[8*b +: 8]),
            .c (chunk_out[8*b +: 8])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_state;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int c = 0; c < NUM_CHUNKS; c++) begin
                    if (cnt_q == CNT_W'(c)) work_d[c*CHUNK_W +: CHUNK_W] = chunk_out;
                end
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // Return to IDLE first; a new block is taken on a later edge.
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        out_state = work_q;
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
module tb_inv_sub_bytes_seq;
    import inv_sub_bytes_seq_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [127:0] in_state;
    logic         iv[3], ordy[3], ir[3], ov[3], bz[3];
    logic [127:0] os[3];
    state_e       sd[3];
    int           lat_exp[3] = '{4, 16, 1};

    localparam logic [127:0] VEC     = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] VEC_EXP = 128'hfbd7f3819ea340bf38a53630d56a0952;

    inv_sub_bytes_seq u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_state(in_state),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_state(os[0]), .busy(bz[0]), .state_dbg(sd[0])
    );
    inv_sub_bytes_seq #(.BYTES_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_state(in_state),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_state(os[1]), .busy(bz[1]), .state_dbg(sd[1])
    );
    inv_sub_bytes_seq #(.BYTES_PER_CYCLE(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_state(in_state),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_state(os[2]), .busy(bz[2]), .state_dbg(sd[2])
    );

    // ---------------- reference model ----------------
    // Inverse S-box derived from GF(2^8) arithmetic: build the forward S-box
    // (multiplicative inverse + affine map) and invert it.
    logic [7:0] inv_tab[256];

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = x;
        logic [7:0] bb = y;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [15:0] t = {v, v} << n;
        return t[15:8];
    endfunction

    task automatic build_model();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] s;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            inv_tab[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] ref_inv(input logic [127:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = inv_tab[s[8*k +: 8]];
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    logic [127:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- driver ----------------
    // Pushes one block into DUT i, waits for the result, optionally stalls
    // out_ready for 'hold' cycles and optionally wiggles the inputs in RUN.
    task automatic run_block(input int i, input logic [127:0] blk, input int hold,
                             input bit scramble, input string tag);
        logic [127:0] exp_v;
        int lat = 0;
        @(negedge clk);
        check({tag, "_in_ready"}, ir[i], 1'b1);
        in_state = blk;
        iv[i]    = 1'b1;
        ordy[i]  = (hold == 0);
        exp_q.push_back(ref_inv(blk));
        @(posedge clk);
        @(negedge clk);
        iv[i] = scramble;
        for (int n = 1; n <= 40; n++) begin
            if (scramble) in_state = rand128();
            @(posedge clk);
            @(negedge clk);
            if (ov[i]) begin
                lat = n;
                break;
            end
        end
        iv[i] = 1'b0;
        if (lat == 0) begin
            check({tag, "_timeout"}, 1'b0, 1'b1);
            void'(exp_q.pop_front());
            ordy[i] = 1'b1;
            return;
        end
        check({tag, "_latency"}, lat, lat_exp[i]);
        exp_v = exp_q.pop_front();
        check({tag, "_out_state"}, os[i], exp_v);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_hold_valid"}, ov[i], 1'b1);
            check({tag, "_hold_state"}, os[i], exp_v);
            check({tag, "_hold_in_ready"}, ir[i], 1'b0);
        end
        ordy[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy[i] = 1'b0;
        check({tag, "_idle_state"}, sd[i], IDLE);
        check({tag, "_idle_in_ready"}, ir[i], 1'b1);
        check({tag, "_idle_out_valid"}, ov[i], 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst      = 1'b1;
        in_state = '0;
        for (int i = 0; i < 3; i++) begin
            iv[i]   = 1'b0;
            ordy[i] = 1'b0;
        end
        build_model();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_in_ready", ir[i], 1'b1);
            check("rst_out_valid", ov[i], 1'b0);
            check("rst_busy", bz[i], 1'b0);
            check("rst_out_state", os[i], 128'h0);
        end
        rst = 1'b0;

        // Known vector, default width.
        run_block(0, VEC, 0, 1'b0, "vec4");
        check("vec4_const", os[0], VEC_EXP);
        run_block(0, {16{8'h63}}, 0, 1'b0, "all63");
        check("all63_const", os[0], 128'h0);
        run_block(0, {16{8'h7c}}, 0, 1'b0, "all7c");
        check("all7c_const", os[0], {16{8'h01}});

        // Output stall and input wiggle during RUN.
        run_block(0, rand128(), 10, 1'b0, "hold");
        run_block(0, rand128(), 0, 1'b1, "scramble");

        // Reset in RUN with cnt=2.
        @(negedge clk);
        in_state = rand128();
        iv[0]    = 1'b1;
        ordy[0]  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_run_busy", bz[0], 1'b1);
        rst = 1'b1;
        #1;
        check("rst_run_out_valid", ov[0], 1'b0);
        check("rst_run_in_ready", ir[0], 1'b1);
        check("rst_run_out_state", os[0], 128'h0);
        check("rst_run_state", sd[0], IDLE);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            check("rst_discard_out_valid", ov[0], 1'b0);
        end
        ordy[0] = 1'b0;
        run_block(0, rand128(), 0, 1'b0, "after_rst");

        // Random blocks at the default width.
        for (int n = 0; n < 10; n++) begin
            run_block(0, rand128(), $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rand4");
        end

        // Narrowest and widest datapaths.
        run_block(1, VEC, 0, 1'b0, "vec1");
        check("vec1_const", os[1], VEC_EXP);
        run_block(2, VEC, 0, 1'b0, "vec16");
        check("vec16_const", os[2], VEC_EXP);
        for (int n = 0; n < 4; n++) begin
            run_block(1, rand128(), $urandom_range(0, 2), 1'($urandom_range(0, 1)), "rand1");
            run_block(2, rand128(), $urandom_range(0, 2), 1'($urandom_range(0, 1)), "rand16");
        end

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
